// File: rtl/axil_check_master.sv
// AXI-Lite link self-test initiator. It reads the magic register and can write, read back and compare a scratch pattern.
// Ports: sys_clk/sys_rst (sync, active high); start -> busy/done/pass/err_code/last_rdata; m_axil_* is the initiator side of AXI-Lite.
// Latency: 3 cycles from start to done for a magic-only run, 7 for a full run against a zero-wait slave. Every handshake is bounded by TIMEOUT.
module axil_check_master #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] MAGIC_ADDR      = 'h0,
  parameter logic [DATA_WIDTH-1:0] MAGIC_NUM       = 'h00114514,
  parameter bit                    SCRATCH_EN      = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] SCRATCH_ADDR    = 'h4,
  parameter logic [DATA_WIDTH-1:0] SCRATCH_PATTERN = 'hA5A55A5A,
  parameter int                    TIMEOUT         = 1024
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [2:0]              err_code,
  output logic [DATA_WIDTH-1:0]   last_rdata,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  typedef enum logic [2:0] {IDLE, MAG_AR, MAG_R, WR_AW_W, WR_B, SCR_AR, SCR_R, FIN} state_t;

  localparam logic [2:0]  ERR_OK      = 3'd0;
  localparam logic [2:0]  ERR_MAGIC   = 3'd1;
  localparam logic [2:0]  ERR_RRESP   = 3'd2;
  localparam logic [2:0]  ERR_BRESP   = 3'd3;
  localparam logic [2:0]  ERR_SCRATCH = 3'd4;
  localparam logic [2:0]  ERR_TIMEOUT = 3'd5;
  localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [2:0]              err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    timed_out;
  logic                    aw_fin, w_fin;

  // Only bit 1 of a response distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_resp;
  assign unused_resp = ^{m_axil_bresp[0], m_axil_rresp[0]};

  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      err_q     <= ERR_OK;
      rdata_q   <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    rdata_d        = rdata_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    m_axil_arvalid = 1'b0;
    m_axil_araddr  = MAGIC_ADDR;
    m_axil_rready  = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    aw_fin         = 1'b0;
    w_fin          = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = MAG_AR;
          err_d   = ERR_OK;
        end
      end
      MAG_AR, SCR_AR: begin
        m_axil_arvalid = 1'b1;
        m_axil_araddr  = (state_q == MAG_AR) ? MAGIC_ADDR : SCRATCH_ADDR;
        if (m_axil_arready) begin
          state_d = (state_q == MAG_AR) ? MAG_R : SCR_R;
        end else if (timed_out) begin
          state_d = FIN;
          err_d   = ERR_TIMEOUT;
        end
      end
      MAG_R: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          if (m_axil_rresp[1]) begin
            state_d = FIN;
            err_d   = ERR_RRESP;
          end else if (m_axil_rdata != MAGIC_NUM) begin
            state_d = FIN;
            err_d   = ERR_MAGIC;
          end else if (SCRATCH_EN) begin
            state_d = WR_AW_W;
          end else begin
            state_d = FIN;
          end
        end else if (timed_out) begin
          state_d = FIN;
          err_d   = ERR_TIMEOUT;
        end
      end
      WR_AW_W: begin
        // Each valid stays up until its own handshake. The done flags
        // remember which handshakes have already happened.
        m_axil_awvalid = !aw_done_q;
        m_axil_wvalid  = !w_done_q;
        aw_fin         = aw_done_q || m_axil_awready;
        w_fin          = w_done_q || m_axil_wready;
        aw_done_d      = aw_fin;
        w_done_d       = w_fin;
        if (aw_fin && w_fin) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (timed_out) begin
          state_d   = FIN;
          err_d     = ERR_TIMEOUT;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_B: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) begin
          if (m_axil_bresp[1]) begin
            state_d = FIN;
            err_d   = ERR_BRESP;
          end else begin
            state_d = SCR_AR;
          end
        end else if (timed_out) begin
          state_d = FIN;
          err_d   = ERR_TIMEOUT;
        end
      end
      SCR_R: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          state_d = FIN;
          if (m_axil_rresp[1]) begin
            err_d = ERR_RRESP;
          end else if (m_axil_rdata != SCRATCH_PATTERN) begin
            err_d = ERR_SCRATCH;
          end
        end else if (timed_out) begin
          state_d = FIN;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase

    // The watchdog counts cycles spent in the current wait state only.
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == FIN)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign busy          = (state_q != IDLE) && (state_q != FIN);
  assign done          = (state_q == FIN);
  assign pass          = (state_q == FIN) && (err_q == ERR_OK);
  assign err_code      = err_q;
  assign last_rdata    = rdata_q;
  assign m_axil_awaddr = SCRATCH_ADDR;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wdata  = SCRATCH_PATTERN;
  assign m_axil_wstrb  = '1;

endmodule

// File: tb/tb_axil_check_master.sv
module tb_axil_check_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic        busy, done, pass;
  logic [2:0]  err_code;
  logic [31:0] last_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  // Knobs for the slave model
  logic [31:0] magic_val     = 32'h00114514;
  bit          arready_en    = 1'b1;
  int          wready_delay  = 0;
  logic [1:0]  bresp_val     = 2'b00;
  logic [1:0]  rresp_val     = 2'b00;
  bit          b_hold        = 1'b0;

  // Slave state and observation counters
  logic [31:0] scratch = 32'h0;
  logic [31:0] rd_addr = 32'h0;
  bit          aw_got = 1'b0, w_got = 1'b0;
  int          w_wait = 0;
  int          ar_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
  int          aw_high = 0, w_high = 0;

  always #5 sys_clk = ~sys_clk;

  axil_check_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAGIC_ADDR(32'h0), .MAGIC_NUM(32'h00114514),
    .SCRATCH_EN(1'b1), .SCRATCH_ADDR(32'h4), .SCRATCH_PATTERN(32'hA5A55A5A), .TIMEOUT(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code), .last_rdata(last_rdata),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  // Behavioural AXI-Lite slave. Handshakes are sampled on the falling edge,
  // and responses are presented just after the following rising edge.
  initial begin : slave
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs, rst_seen;
    logic [31:0] wd_s;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    forever begin
      @(negedge sys_clk);
      rst_seen = sys_rst;
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
      wd_s  = wdata;
      if (ar_hs) begin ar_hs_cnt++; rd_addr = araddr; end
      if (aw_hs) aw_hs_cnt++;
      if (w_hs)  w_hs_cnt++;
      if (b_hs)  b_hs_cnt++;
      if (awvalid) aw_high++;
      if (wvalid)  w_high++;
      if (w_hs) w_wait = 0; else if (wvalid) w_wait++;
      @(posedge sys_clk);
      #1;
      if (rst_seen) begin
        bvalid = 1'b0; rvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; w_wait = 0;
      end else begin
        if (r_hs) rvalid = 1'b0;
        if (ar_hs) begin
          rvalid = 1'b1;
          rresp  = rresp_val;
          rdata  = (rd_addr == 32'h0) ? magic_val : ((rd_addr == 32'h4) ? scratch : 32'h0);
        end
        if (aw_hs) aw_got = 1'b1;
        if (w_hs) begin w_got = 1'b1; scratch = wd_s; end
        if (b_hs) bvalid = 1'b0;
        if (aw_got && w_got && !b_hold) begin
          bvalid = 1'b1; bresp = bresp_val; aw_got = 1'b0; w_got = 1'b0;
        end
      end
      arready = arready_en;
      awready = 1'b1;
      wready  = (w_wait >= wready_delay);
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_counts;
    ar_hs_cnt = 0; aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0;
    aw_high = 0; w_high = 0; scratch = 32'h0;
  endtask

  // Pulses start for one cycle, then returns the number of cycles until done is seen (-1 if it never rises).
  task automatic run_test(output int latency);
    start = 1'b1;
    tick();
    start = 1'b0;
    latency = -1;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin latency = k; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_code); end
    n_checks++; if (last_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", last_rdata); end
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    n_checks++;
    if ({wstrb, awprot, arprot} !== {4'hF, 6'b0}) begin
      n_fail++; $display("FAIL reset_strb_prot: got %h/%0d/%0d want f/0/0", wstrb, awprot, arprot);
    end
  endtask

  task automatic test_full_pass;
    clear_counts();
    run_test(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL full_latency: got %0d want 7", lat); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL full_pass: got %b want 1", pass); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL full_err: got %0d want 0", err_code); end
    n_checks++; if (last_rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL full_rdata: got %h want a5a55a5a", last_rdata); end
    n_checks++; if (ar_hs_cnt !== 2) begin n_fail++; $display("FAIL full_ar_count: got %0d want 2", ar_hs_cnt); end
    n_checks++; if (b_hs_cnt !== 1) begin n_fail++; $display("FAIL full_b_count: got %0d want 1", b_hs_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", busy); end
  endtask

  task automatic test_magic_mismatch;
    clear_counts();
    magic_val = 32'hDEADBEEF;
    run_test(lat);
    magic_val = 32'h00114514;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL magic_latency: got %0d want 3", lat); end
    n_checks++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL magic_err: got %0d want 1", err_code); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL magic_pass: got %b want 0", pass); end
    n_checks++; if (last_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL magic_rdata: got %h want deadbeef", last_rdata); end
    n_checks++; if (aw_high + w_high !== 0) begin n_fail++; $display("FAIL magic_no_write: got %0d want 0", aw_high + w_high); end
  endtask

  task automatic test_wready_delay;
    clear_counts();
    wready_delay = 5;
    run_test(lat);
    wready_delay = 0;
    n_checks++; if (aw_high !== 1) begin n_fail++; $display("FAIL wdly_awvalid_cycles: got %0d want 1", aw_high); end
    n_checks++; if (w_high !== 6) begin n_fail++; $display("FAIL wdly_wvalid_cycles: got %0d want 6", w_high); end
    n_checks++; if (b_hs_cnt !== 1) begin n_fail++; $display("FAIL wdly_b_count: got %0d want 1", b_hs_cnt); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL wdly_pass: got %b want 1", pass); end
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL wdly_latency: got %0d want 12", lat); end
  endtask

  task automatic test_bresp_err;
    clear_counts();
    bresp_val = 2'b10;
    run_test(lat);
    bresp_val = 2'b00;
    n_checks++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL bresp_err: got %0d want 3", err_code); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL bresp_pass: got %b want 0", pass); end
    n_checks++; if (ar_hs_cnt !== 1) begin n_fail++; $display("FAIL bresp_no_scratch_read: got %0d want 1", ar_hs_cnt); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bresp_latency: got %0d want 5", lat); end
  endtask

  task automatic test_rresp_err;
    clear_counts();
    rresp_val = 2'b11;
    run_test(lat);
    rresp_val = 2'b00;
    n_checks++; if (err_code !== 3'd2) begin n_fail++; $display("FAIL rresp_err: got %0d want 2", err_code); end
    n_checks++; if (last_rdata !== 32'h00114514) begin n_fail++; $display("FAIL rresp_rdata: got %h want 00114514", last_rdata); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rresp_latency: got %0d want 3", lat); end
  endtask

  task automatic test_timeout;
    clear_counts();
    arready_en = 1'b0;
    run_test(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d want 17", lat); end
    n_checks++; if (err_code !== 3'd5) begin n_fail++; $display("FAIL timeout_err: got %0d want 5", err_code); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL timeout_pass: got %b want 0", pass); end
    tick();
    n_checks++; if ({arvalid, rready} !== 2'b00) begin n_fail++; $display("FAIL timeout_ar_dropped: got %b want 00", {arvalid, rready}); end
    n_checks++; if (ar_hs_cnt !== 0) begin n_fail++; $display("FAIL timeout_no_ar: got %0d want 0", ar_hs_cnt); end
    arready_en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    bit seen;
    // A second start while busy must not disturb the run in progress.
    clear_counts();
    start = 1'b1; tick(); start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 200; k++) begin
      if (done) begin lat = k; break; end
      tick();
    end
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 7", lat); end
    n_checks++; if (ar_hs_cnt !== 2) begin n_fail++; $display("FAIL busy_start_ar_count: got %0d want 2", ar_hs_cnt); end
    tick(); tick(); tick();
    n_checks++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL done_held: got %b want 11", {done, pass}); end

    // Reset while waiting in WR_B, where the slave withholds B.
    b_hold = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bready) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_reach_wr_b: got %b want 1", seen); end
    sys_rst = 1'b1;
    tick();
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {busy, done, pass}); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_code); end
    n_checks++; if (last_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", last_rdata); end
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      n_fail++; $display("FAIL rst_handshake: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    sys_rst = 1'b0;
    b_hold  = 1'b0;
    tick(); tick();
    clear_counts();
    run_test(lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL post_rst_latency: got %0d want 7", lat); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL post_rst_pass: got %b want 1", pass); end
    n_checks++; if (last_rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL post_rst_rdata: got %h want a5a55a5a", last_rdata); end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_magic_mismatch();
    test_wready_delay();
    test_bresp_err();
    test_rresp_err();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_check_master.md
Name: axil_check_master

Overview:
- AXI-Lite initiator that runs a fixed link self-test against the shell's check slave.
- The check slave answers a magic number at a fixed address and provides a scratch register.
- On `start`: reads the magic register, then optionally writes a scratch pattern, reads it back and compares.
- Reports busy/done/pass plus an error code. Sits in the role or a debug harness, driving the `axil_check` channel.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width (fixed 32; wstrb = 4 bits).
- MAGIC_ADDR, 'h0, address of the magic register.
- MAGIC_NUM, 'h00114514, expected magic value.
- SCRATCH_EN, 1, 1 = run the scratch write/readback phase.
- SCRATCH_ADDR, 'h4, scratch register address.
- SCRATCH_PATTERN, 'hA5A55A5A, value written to scratch.
- TIMEOUT, 1024, maximum cycles waited for any single handshake.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to run the test.
- busy  out  1  test in progress.
- done  out  1  level; test finished; held until the next accepted start.
- pass  out  1  valid when done; 1 = all checks ok.
- err_code  out  3  0 ok, 1 magic mismatch, 2 read SLVERR/DECERR, 3 write resp error, 4 scratch mismatch, 5 timeout.
- last_rdata  out  32  last read data captured.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel.
- m_axil_awready  in  1  write address channel.
- m_axil_wdata/wstrb/wvalid  out  32/4/1  write data channel.
- m_axil_wready  in  1  write data channel.
- m_axil_bresp  in  2  write response.
- m_axil_bvalid  in  1  write response.
- m_axil_bready  out  1  write response.
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel.
- m_axil_arready  in  1  read address channel.
- m_axil_rdata/rresp/rvalid  in  32/2/1  read data channel.
- m_axil_rready  out  1  read data channel.

Behaviour:
- Reset values:
  - All valid/ready outputs 0; busy, done, pass 0; err_code 0; last_rdata 0.
  - awprot = arprot = 0 and wstrb = 4'hF at all times.
- FSM states: IDLE, MAG_AR, MAG_R, WR_AW_W, WR_B, SCR_AR, SCR_R, FIN.
- IDLE:
  - On start → MAG_AR. Clear done/pass/err_code, set busy.
- MAG_AR:
  - arvalid = 1, araddr = MAGIC_ADDR.
  - On arvalid & arready → MAG_R. arvalid drops the next cycle.
- MAG_R:
  - rready = 1. On rvalid, capture rdata into last_rdata.
  - If rresp[1] → FIN, err 2.
  - Else if rdata ≠ MAGIC_NUM → FIN, err 1.
  - Else → WR_AW_W if SCRATCH_EN, otherwise FIN with pass.
- WR_AW_W:
  - awvalid and wvalid asserted together in the same cycle.
  - Each deasserts independently after its own handshake. Either order is legal, including the same cycle.
  - Exit to WR_B only when both handshakes are complete.
  - valid must never drop before its handshake (AXI rule).
- WR_B:
  - bready = 1. On bvalid: bresp[1] → FIN err 3, else → SCR_AR.
- SCR_AR and SCR_R:
  - Same as the MAG states, using SCRATCH_ADDR.
  - Mismatch against SCRATCH_PATTERN → err 4.
  - Resp error → err 2.
  - Otherwise → FIN with pass.
- FIN:
  - busy = 0, done = 1, pass = (err_code == 0).
  - Stay until start, then restart exactly as from IDLE (done clears the same cycle).
- start while busy: ignored.
- Timeout:
  - A 16-bit counter clears on every state change and increments each cycle in non-IDLE, non-FIN states.
  - At TIMEOUT-1 cycles: → FIN, err 5.
  - All valid/ready outputs are 0 the next cycle.
  - Later stray rvalid/bvalid are ignored.
- Latency: minimum 2 cycles per phase with a zero-wait slave.
  - Magic-only run: start to done = 3 cycles.
  - Full run: 7 cycles.
- rready/bready are asserted only in their wait states. A response arriving earlier stalls on the slave side.
- sys_rst mid-transaction: immediate return to reset values. The outstanding transaction is abandoned; the slave is expected to be reset together with it.

Test Plan:
- Zero-wait slave returning 'h00114514; scratch echoes writes; start pulse → done = 1, pass = 1, err_code = 0, last_rdata = 'hA5A55A5A, done 7 cycles after start.
- Slave returns 'hDEADBEEF at addr 0 → done, pass = 0, err_code = 1, last_rdata = 'hDEADBEEF, no AW/W issued.
- wready delayed 5 cycles after awready, scratch ok → awvalid high 1 cycle, wvalid high 6 cycles, single B, pass = 1.
- Slave bresp = 2'b10 → err_code = 3, pass = 0, no scratch read issued.
- arready never asserted, TIMEOUT = 16 → done at cycle 17 after start, err_code = 5, arvalid = 0 afterwards.
- start re-pulsed while busy, and sys_rst during WR_B → no effect while busy; on reset all outputs go to 0 the next cycle; a new start runs a clean test to pass.
